idu: RTL

Instruction decode unit: the stage directly downstream of instruction fetch. It accepts one fetched instruction and its PC per handshake, decodes RV32I base integer instructions into execute-stage control fields, and holds the result in an output register backed by a one-entry skid buffer. This keeps fetch flowing one instruction per cycle under execute-stage backpressure, and supports a flush from the execute stage on control-flow redirect.

---
 rtl/idu_pkg.sv | 84 ++++++++
 rtl/idu_if.sv | 43 ++++
 rtl/idu_decode.sv | 114 +++++++++++
 rtl/idu.sv | 68 ++++++
 4 files changed

// File: rtl/idu_pkg.sv
// Shared decode types for the instruction decode unit: opcodes, ALU codes,
// immediate formats and the decoded bundle held in the output/skid registers.
package idu_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_SLL    = 4'd2;
   localparam logic [3:0] ALU_SLT    = 4'd3;
   localparam logic [3:0] ALU_SLTU   = 4'd4;
   localparam logic [3:0] ALU_XOR    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_OR     = 4'd8;
   localparam logic [3:0] ALU_AND    = 4'd9;
   localparam logic [3:0] ALU_PASS_B = 4'd10;

   typedef enum logic [2:0] {
      IMM_N, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_fmt_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [3:0]  alu_op;
      logic        src1_pc;
      logic        src2_imm;
      logic        rd_wen;
      logic        mem_ren;
      logic        mem_wen;
      logic [2:0]  mem_size;
      logic        branch;
      logic [2:0]  br_cond;
      logic        jump;
      logic        ebreak;
      logic        illegal;
   } bundle_t;

   // alt selects SUB/SRA (instruction bit 30)
   function automatic logic [3:0] alu_of(logic [2:0] f3, logic alt);
      logic [3:0] op;
      unique case (f3)
         3'd0:    op = alt ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = alt ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic logic [31:0] imm_of(logic [31:0] i, imm_fmt_t f);
      logic [31:0] v;
      unique case (f)
         IMM_I:   v = {{20{i[31]}}, i[31:20]};
         IMM_S:   v = {{20{i[31]}}, i[31:25], i[11:7]};
         IMM_B:   v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         IMM_U:   v = {i[31:12], 12'h000};
         IMM_J:   v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         default: v = 32'h0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/idu_if.sv
// Fetch-side and execute-side handshake bundle of the decode unit.
// slave = decode unit, master = fetch/execute environment.
interface idu_if;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        ifu_valid;
   logic        idu_ready;
   logic        exu_ready;
   logic        exu_valid;
   logic [31:0] exu_pc;
   logic [4:0]  exu_rs1;
   logic [4:0]  exu_rs2;
   logic [4:0]  exu_rd;
   logic [31:0] exu_imm;
   logic [3:0]  exu_alu_op;
   logic        exu_src1_pc;
   logic        exu_src2_imm;
   logic        exu_rd_wen;
   logic        exu_mem_ren;
   logic        exu_mem_wen;
   logic [2:0]  exu_mem_size;
   logic        exu_branch;
   logic [2:0]  exu_br_cond;
   logic        exu_jump;
   logic        exu_ebreak;
   logic        exu_illegal;

   modport slave (
      input  inst, inst_pc, ifu_valid, exu_ready,
      output idu_ready, exu_valid, exu_pc, exu_rs1, exu_rs2, exu_rd,
      output exu_imm, exu_alu_op, exu_src1_pc, exu_src2_imm, exu_rd_wen,
      output exu_mem_ren, exu_mem_wen, exu_mem_size, exu_branch,
      output exu_br_cond, exu_jump, exu_ebreak, exu_illegal
   );

   modport master (
      output inst, inst_pc, ifu_valid, exu_ready,
      input  idu_ready, exu_valid, exu_pc, exu_rs1, exu_rs2, exu_rd,
      input  exu_imm, exu_alu_op, exu_src1_pc, exu_src2_imm, exu_rd_wen,
      input  exu_mem_ren, exu_mem_wen, exu_mem_size, exu_branch,
      input  exu_br_cond, exu_jump, exu_ebreak, exu_illegal
   );
endinterface

// File: rtl/idu_decode.sv
// Combinational RV32I decoder: instruction word + PC to decoded bundle.
// IDU_RV32E_EN: register indices >= 16 in used fields are illegal.
module idu_decode
   import idu_pkg::*;
(
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   output bundle_t     dec
);
   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   imm_fmt_t   fmt;
   logic [3:0] alu;
   logic       use_rd, bad, regs_bad, ill;
   logic       pc_a, imm_b, ld, st, br, jmp, brk;

   assign opc = inst[6:0];
   assign f3  = inst[14:12];
   assign f7  = inst[31:25];

   always_comb begin
      fmt    = IMM_N;
      alu    = ALU_ADD;
      use_rd = 1'b0;
      bad    = 1'b0;
      pc_a   = 1'b0;
      imm_b  = 1'b0;
      ld     = 1'b0;
      st     = 1'b0;
      br     = 1'b0;
      jmp    = 1'b0;
      brk    = 1'b0;
      unique case (opc)
         OPC_LUI: begin
            fmt = IMM_U; alu = ALU_PASS_B; use_rd = 1'b1; imm_b = 1'b1;
         end
         OPC_AUIPC: begin
            fmt = IMM_U; use_rd = 1'b1; pc_a = 1'b1; imm_b = 1'b1;
         end
         OPC_JAL: begin
            fmt = IMM_J; use_rd = 1'b1; pc_a = 1'b1; imm_b = 1'b1; jmp = 1'b1;
         end
         OPC_JALR: begin
            fmt = IMM_I; use_rd = 1'b1; pc_a = 1'b1; imm_b = 1'b1; jmp = 1'b1;
            bad = f3 != 3'd0;
         end
         OPC_BRANCH: begin
            fmt = IMM_B; alu = ALU_SUB; br = 1'b1;
            bad = f3[2:1] == 2'b01;
         end
         OPC_LOAD: begin
            fmt = IMM_I; use_rd = 1'b1; imm_b = 1'b1; ld = 1'b1;
            bad = (f3 == 3'd3) | (f3[2] & f3[1]);
         end
         OPC_STORE: begin
            fmt = IMM_S; imm_b = 1'b1; st = 1'b1;
            bad = f3[2] | (f3[1] & f3[0]);
         end
         OPC_OPIMM: begin
            fmt = IMM_I; use_rd = 1'b1; imm_b = 1'b1;
            alu = alu_of(f3, (f3 == 3'd5) & inst[30]);
            bad = ((f3 == 3'd1) & (f7 != 7'h00)) |
                  ((f3 == 3'd5) & ({f7[6], f7[4:0]} != 6'h00));
         end
         OPC_OP: begin
            use_rd = 1'b1;
            alu = alu_of(f3, inst[30]);
            bad = (f7 != 7'h00) &
                  !((f7 == 7'h20) & ((f3 == 3'd0) | (f3 == 3'd5)));
         end
         OPC_FENCE:  bad = f3 != 3'd0;
         OPC_SYSTEM: begin
            brk = inst == INST_EBREAK;
            bad = !brk;
         end
         default: bad = 1'b1;
      endcase
   end

`ifdef IDU_RV32E_EN
   logic use_rs1, use_rs2;
   assign use_rs1 = opc inside {OPC_JALR, OPC_LOAD, OPC_OPIMM,
                                OPC_STORE, OPC_BRANCH, OPC_OP};
   assign use_rs2 = opc inside {OPC_STORE, OPC_BRANCH, OPC_OP};
   assign regs_bad = (use_rs1 & inst[19]) | (use_rs2 & inst[24]) |
                     (use_rd & inst[11]);
`else
   assign regs_bad = 1'b0;
`endif

   assign ill = bad | regs_bad;

   always_comb begin
      dec          = '0;
      dec.pc       = pc;
      dec.rs1      = inst[19:15];
      dec.rs2      = inst[24:20];
      dec.rd       = inst[11:7];
      dec.imm      = imm_of(inst, fmt);
      dec.alu_op   = alu;
      dec.src1_pc  = pc_a & !ill;
      dec.src2_imm = imm_b & !ill;
      dec.rd_wen   = use_rd & (inst[11:7] != 5'd0) & !ill;
      dec.mem_ren  = ld & !ill;
      dec.mem_wen  = st & !ill;
      dec.mem_size = (ld | st) ? f3 : 3'd0;
      dec.branch   = br & !ill;
      dec.br_cond  = br ? f3 : 3'd0;
      dec.jump     = jmp & !ill;
      dec.ebreak   = brk & !ill;
      dec.illegal  = ill;
   end
endmodule

// File: rtl/idu.sv
// Decode stage top: output register plus one-entry skid buffer.
// Optional build macro IDU_RV32E_EN (see idu_decode).
module idu
   import idu_pkg::*;
(
   input logic  clk,
   input logic  rst,
   input logic  flush,
   idu_if.slave bus
);
   bundle_t dec, out_q, skid_q;
   logic    out_v, skid_v, accept, drain;

   idu_decode u_dec (
      .inst (bus.inst),
      .pc   (bus.inst_pc),
      .dec  (dec)
   );

   assign accept = bus.ifu_valid & ~skid_v;
   assign drain  = out_v & bus.exu_ready;

   // skid is only ever filled while the output register stalls,
   // so a draining skid can never coincide with a new accept
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
         out_q  <= '0;
         skid_q <= '0;
      end else if (flush) begin
         out_v  <= 1'b0;
         skid_v <= 1'b0;
      end else if (!out_v || drain) begin
         if (skid_v) begin
            out_q  <= skid_q;
            out_v  <= 1'b1;
            skid_v <= 1'b0;
         end else begin
            out_v <= accept;
            if (accept) out_q <= dec;
         end
      end else if (accept) begin
         skid_q <= dec;
         skid_v <= 1'b1;
      end
   end

   assign bus.idu_ready    = ~skid_v;
   assign bus.exu_valid    = out_v;
   assign bus.exu_pc       = out_q.pc;
   assign bus.exu_rs1      = out_q.rs1;
   assign bus.exu_rs2      = out_q.rs2;
   assign bus.exu_rd       = out_q.rd;
   assign bus.exu_imm      = out_q.imm;
   assign bus.exu_alu_op   = out_q.alu_op;
   assign bus.exu_src1_pc  = out_q.src1_pc;
   assign bus.exu_src2_imm = out_q.src2_imm;
   assign bus.exu_rd_wen   = out_q.rd_wen;
   assign bus.exu_mem_ren  = out_q.mem_ren;
   assign bus.exu_mem_wen  = out_q.mem_wen;
   assign bus.exu_mem_size = out_q.mem_size;
   assign bus.exu_branch   = out_q.branch;
   assign bus.exu_br_cond  = out_q.br_cond;
   assign bus.exu_jump     = out_q.jump;
   assign bus.exu_ebreak   = out_q.ebreak;
   assign bus.exu_illegal  = out_q.illegal;
endmodule
